// File: rtl/mem_wb_backend_pkg.sv
// rtl/mem_wb_backend_pkg.sv - shared widths and register indices for the MEM/WB back end
package mem_wb_backend_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_PC_W   = 10;
  localparam logic [4:0] RA_REG   = 5'd31;
  localparam logic [4:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/mem_wb_backend_dmem_dp.sv
// rtl/mem_wb_backend_dmem_dp.sv - dual-port sync RAM, lane 2 wins same-address writes
module mem_wb_backend_dmem_dp
  import mem_wb_backend_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              re1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              re2,
  input  logic              we2,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Lane 1 is older, so lane 2 sees its store; lane 1 never sees lane 2's store.
  always_ff @(posedge clk) begin
    if (re1) rdata1 <= mem[addr1];
    if (re2) rdata2 <= (we1 && addr1 == addr2) ? wdata1 : mem[addr2];
    if (we1) mem[addr1] <= wdata1;
    if (we2) mem[addr2] <= wdata2;
  end
endmodule

// File: rtl/mem_wb_backend.sv
// rtl/mem_wb_backend.sv - MEM stage, branch correction/squash and MEM/WB register for both lanes
module mem_wb_backend
  import mem_wb_backend_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PC_W   = DEF_PC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] aluRes1_MEM,
  input  logic [DATA_W-1:0] aluRes2_MEM,
  input  logic [DATA_W-1:0] forwardBRes1_MEM,
  input  logic [DATA_W-1:0] forwardBRes2_MEM,
  input  logic              MemReadEn1_MEM,
  input  logic              MemReadEn2_MEM,
  input  logic              MemtoReg1_MEM,
  input  logic              MemtoReg2_MEM,
  input  logic              MemWriteEn1_MEM,
  input  logic              MemWriteEn2_MEM,
  input  logic              RegWriteEn1_MEM,
  input  logic              RegWriteEn2_MEM,
  input  logic              jal1_MEM,
  input  logic              jal2_MEM,
  input  logic [4:0]        DestReg1_MEM,
  input  logic [4:0]        DestReg2_MEM,
  input  logic [PC_W-1:0]   return_addr1_MEM,
  input  logic [PC_W-1:0]   return_addr2_MEM,
  input  logic              Branch1_MEM,
  input  logic              Branch2_MEM,
  input  logic              taken1_MEM,
  input  logic              taken2_MEM,
  output logic              correct_en,
  output logic [PC_W-1:0]   correction,
  output logic              flush_IFID,
  output logic              flush_IDEX,
  output logic [DATA_W-1:0] aluRes1_MEM_fwd,
  output logic [DATA_W-1:0] aluRes2_MEM_fwd,
  output logic              regWrite1_WB,
  output logic              regWrite2_WB,
  output logic              jal1_WB,
  output logic              jal2_WB,
  output logic [4:0]        writeReg1_WB,
  output logic [4:0]        writeReg2_WB,
  output logic [DATA_W-1:0] writeData1_WB,
  output logic [DATA_W-1:0] writeData2_WB,
  output logic [DATA_W-1:0] aluRes1_WB,
  output logic [DATA_W-1:0] aluRes2_WB,
  output logic              squash_MEM
);
  localparam int ZX_W = DATA_W - PC_W;

  logic squash_q, v1, v2, mis1, mis2;
  logic rw1_q, rw2_q, m2r1_q, m2r2_q;
  logic [PC_W-1:0] ra1_q, ra2_q;
  logic [DATA_W-1:0] rdata1, rdata2;

  // Anything sitting in MEM the cycle after a redirect is wrong-path.
  assign v1   = !squash_q;
  assign mis1 = Branch1_MEM && !taken1_MEM && v1;
  assign v2   = v1 && !mis1;
  assign mis2 = Branch2_MEM && !taken2_MEM && v2;

  assign correct_en = mis1 || mis2;
  assign correction = mis1 ? return_addr1_MEM : return_addr2_MEM;
  assign flush_IFID = correct_en;
  assign flush_IDEX = correct_en;
  assign squash_MEM = squash_q;

  assign aluRes1_MEM_fwd = jal1_MEM ? {{ZX_W{1'b0}}, return_addr1_MEM} : aluRes1_MEM;
  assign aluRes2_MEM_fwd = jal2_MEM ? {{ZX_W{1'b0}}, return_addr2_MEM} : aluRes2_MEM;

  mem_wb_backend_dmem_dp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dmem_dp (
    .clk    (clk),
    .re1    (MemReadEn1_MEM),
    .we1    (MemWriteEn1_MEM && v1),
    .addr1  (aluRes1_MEM[ADDR_W-1:0]),
    .wdata1 (forwardBRes1_MEM),
    .re2    (MemReadEn2_MEM),
    .we2    (MemWriteEn2_MEM && v2),
    .addr2  (aluRes2_MEM[ADDR_W-1:0]),
    .wdata2 (forwardBRes2_MEM),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      squash_q     <= 1'b0;
      rw1_q        <= 1'b0;
      rw2_q        <= 1'b0;
      jal1_WB      <= 1'b0;
      jal2_WB      <= 1'b0;
      m2r1_q       <= 1'b0;
      m2r2_q       <= 1'b0;
      writeReg1_WB <= ZERO_REG;
      writeReg2_WB <= ZERO_REG;
      aluRes1_WB   <= '0;
      aluRes2_WB   <= '0;
      ra1_q        <= '0;
      ra2_q        <= '0;
    end else begin
      squash_q     <= correct_en;
      rw1_q        <= RegWriteEn1_MEM && v1;
      rw2_q        <= RegWriteEn2_MEM && v2;
      jal1_WB      <= jal1_MEM && v1;
      jal2_WB      <= jal2_MEM && v2;
      m2r1_q       <= MemtoReg1_MEM && v1;
      m2r2_q       <= MemtoReg2_MEM && v2;
      writeReg1_WB <= jal1_MEM ? RA_REG : DestReg1_MEM;
      writeReg2_WB <= jal2_MEM ? RA_REG : DestReg2_MEM;
      aluRes1_WB   <= aluRes1_MEM;
      aluRes2_WB   <= aluRes2_MEM;
      ra1_q        <= return_addr1_MEM;
      ra2_q        <= return_addr2_MEM;
    end
  end

  assign writeData1_WB = m2r1_q ? rdata1 : (jal1_WB ? {{ZX_W{1'b0}}, ra1_q} : aluRes1_WB);
  assign writeData2_WB = m2r2_q ? rdata2 : (jal2_WB ? {{ZX_W{1'b0}}, ra2_q} : aluRes2_WB);
  assign regWrite1_WB  = (rw1_q || jal1_WB) && (writeReg1_WB != ZERO_REG);
  assign regWrite2_WB  = (rw2_q || jal2_WB) && (writeReg2_WB != ZERO_REG);
endmodule

// File: tb/tb_mem_wb_backend.sv
// tb/tb_mem_wb_backend.sv - self-checking bench for mem_wb_backend
module tb_mem_wb_backend;
  typedef struct {
    logic mr, m2r, mw, rw, jal, br, tk;
    logic [4:0] dest;
    logic [9:0] ret;
    logic [31:0] alu, sd;
  } ins_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [31:0] aluRes1_MEM, aluRes2_MEM, forwardBRes1_MEM, forwardBRes2_MEM;
  logic MemReadEn1_MEM, MemReadEn2_MEM, MemtoReg1_MEM, MemtoReg2_MEM;
  logic MemWriteEn1_MEM, MemWriteEn2_MEM, RegWriteEn1_MEM, RegWriteEn2_MEM;
  logic jal1_MEM, jal2_MEM, Branch1_MEM, Branch2_MEM, taken1_MEM, taken2_MEM;
  logic [4:0] DestReg1_MEM, DestReg2_MEM;
  logic [9:0] return_addr1_MEM, return_addr2_MEM;
  logic correct_en, flush_IFID, flush_IDEX, squash_MEM;
  logic [9:0] correction;
  logic [31:0] aluRes1_MEM_fwd, aluRes2_MEM_fwd;
  logic regWrite1_WB, regWrite2_WB, jal1_WB, jal2_WB;
  logic [4:0] writeReg1_WB, writeReg2_WB;
  logic [31:0] writeData1_WB, writeData2_WB, aluRes1_WB, aluRes2_WB;

  mem_wb_backend dut (
    .clk(clk), .rst(rst),
    .aluRes1_MEM(aluRes1_MEM), .aluRes2_MEM(aluRes2_MEM),
    .forwardBRes1_MEM(forwardBRes1_MEM), .forwardBRes2_MEM(forwardBRes2_MEM),
    .MemReadEn1_MEM(MemReadEn1_MEM), .MemReadEn2_MEM(MemReadEn2_MEM),
    .MemtoReg1_MEM(MemtoReg1_MEM), .MemtoReg2_MEM(MemtoReg2_MEM),
    .MemWriteEn1_MEM(MemWriteEn1_MEM), .MemWriteEn2_MEM(MemWriteEn2_MEM),
    .RegWriteEn1_MEM(RegWriteEn1_MEM), .RegWriteEn2_MEM(RegWriteEn2_MEM),
    .jal1_MEM(jal1_MEM), .jal2_MEM(jal2_MEM),
    .DestReg1_MEM(DestReg1_MEM), .DestReg2_MEM(DestReg2_MEM),
    .return_addr1_MEM(return_addr1_MEM), .return_addr2_MEM(return_addr2_MEM),
    .Branch1_MEM(Branch1_MEM), .Branch2_MEM(Branch2_MEM),
    .taken1_MEM(taken1_MEM), .taken2_MEM(taken2_MEM),
    .correct_en(correct_en), .correction(correction),
    .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
    .aluRes1_MEM_fwd(aluRes1_MEM_fwd), .aluRes2_MEM_fwd(aluRes2_MEM_fwd),
    .regWrite1_WB(regWrite1_WB), .regWrite2_WB(regWrite2_WB),
    .jal1_WB(jal1_WB), .jal2_WB(jal2_WB),
    .writeReg1_WB(writeReg1_WB), .writeReg2_WB(writeReg2_WB),
    .writeData1_WB(writeData1_WB), .writeData2_WB(writeData2_WB),
    .aluRes1_WB(aluRes1_WB), .aluRes2_WB(aluRes2_WB),
    .squash_MEM(squash_MEM)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: 16 tracked memory words and "did the previous cycle redirect".
  logic [31:0] mem_m [0:15];
  bit          sq_m;
  bit          e_ce;
  logic [9:0]  e_corr;
  bit          pw [2];
  logic [3:0]  pa [2];
  logic [31:0] pd [2];
  logic        e_rw [2], e_jal [2];
  logic [4:0]  e_wr [2];
  logic [31:0] e_wd [2], e_alu [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic ins_t nop();
    ins_t r;
    r = '{mr:1'b0, m2r:1'b0, mw:1'b0, rw:1'b0, jal:1'b0, br:1'b0, tk:1'b0,
          dest:5'd0, ret:10'd0, alu:32'd0, sd:32'd0};
    return r;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t r;
    logic [3:0] addr;
    r = nop();
    addr   = 4'($urandom_range(0, 15));
    r.dest = 5'($urandom);
    r.ret  = 10'($urandom);
    r.alu  = $urandom;
    r.sd   = $urandom;
    case ($urandom_range(0, 4))
      0: r.rw = 1'b1;
      1: begin r.mr = 1'b1; r.m2r = 1'b1; r.rw = 1'b1; r.alu = {22'($urandom), 6'd0, addr}; end
      2: begin r.mw = 1'b1; r.alu = {22'($urandom), 6'd0, addr}; end
      3: begin r.br = 1'b1; r.tk = 1'($urandom_range(0, 1)); end
      default: r.jal = 1'b1;
    endcase
    return r;
  endfunction

  task automatic set_in(input ins_t a, input ins_t b);
    aluRes1_MEM = a.alu;      aluRes2_MEM = b.alu;
    forwardBRes1_MEM = a.sd;  forwardBRes2_MEM = b.sd;
    MemReadEn1_MEM = a.mr;    MemReadEn2_MEM = b.mr;
    MemtoReg1_MEM = a.m2r;    MemtoReg2_MEM = b.m2r;
    MemWriteEn1_MEM = a.mw;   MemWriteEn2_MEM = b.mw;
    RegWriteEn1_MEM = a.rw;   RegWriteEn2_MEM = b.rw;
    jal1_MEM = a.jal;         jal2_MEM = b.jal;
    DestReg1_MEM = a.dest;    DestReg2_MEM = b.dest;
    return_addr1_MEM = a.ret; return_addr2_MEM = b.ret;
    Branch1_MEM = a.br;       Branch2_MEM = b.br;
    taken1_MEM = a.tk;        taken2_MEM = b.tk;
  endtask

  // Present a lane pair in MEM, predict everything, and check the same-cycle outputs.
  task automatic drive(input ins_t a, input ins_t b);
    ins_t l [2];
    bit v [2];
    bit mis [2];
    logic [31:0] rd [2];
    logic [4:0] wr;
    bit jv;
    set_in(a, b);
    l[0] = a; l[1] = b;
    v[0]   = !sq_m;
    mis[0] = v[0] && a.br && !a.tk;
    v[1]   = v[0] && !mis[0];
    mis[1] = v[1] && b.br && !b.tk;
    e_ce   = mis[0] || mis[1];
    e_corr = mis[0] ? a.ret : b.ret;
    rd[0] = mem_m[a.alu[3:0]];
    rd[1] = (a.mw && v[0] && a.alu[9:0] == b.alu[9:0]) ? a.sd : mem_m[b.alu[3:0]];
    for (int i = 0; i < 2; i++) begin
      pw[i] = l[i].mw && v[i];
      pa[i] = l[i].alu[3:0];
      pd[i] = l[i].sd;
      wr = l[i].jal ? 5'd31 : l[i].dest;
      jv = l[i].jal && v[i];
      e_wr[i]  = wr;
      e_jal[i] = jv;
      e_alu[i] = l[i].alu;
      e_wd[i]  = (l[i].m2r && v[i]) ? rd[i] : (jv ? {22'd0, l[i].ret} : l[i].alu);
      e_rw[i]  = ((l[i].rw && v[i]) || jv) && (wr != 5'd0);
    end
    #1;
    check("correct_en", {31'd0, correct_en}, {31'd0, e_ce});
    check("correction", {22'd0, correction}, {22'd0, e_corr});
    check("flush_IFID", {31'd0, flush_IFID}, {31'd0, e_ce});
    check("flush_IDEX", {31'd0, flush_IDEX}, {31'd0, e_ce});
    check("squash_MEM", {31'd0, squash_MEM}, {31'd0, sq_m});
    check("fwd1", aluRes1_MEM_fwd, a.jal ? {22'd0, a.ret} : a.alu);
    check("fwd2", aluRes2_MEM_fwd, b.jal ? {22'd0, b.ret} : b.alu);
  endtask

  task automatic clock();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) if (pw[i]) mem_m[pa[i]] = pd[i];
    sq_m = e_ce;
    check("regWrite1_WB", {31'd0, regWrite1_WB}, {31'd0, e_rw[0]});
    check("regWrite2_WB", {31'd0, regWrite2_WB}, {31'd0, e_rw[1]});
    check("jal1_WB", {31'd0, jal1_WB}, {31'd0, e_jal[0]});
    check("jal2_WB", {31'd0, jal2_WB}, {31'd0, e_jal[1]});
    check("writeReg1_WB", {27'd0, writeReg1_WB}, {27'd0, e_wr[0]});
    check("writeReg2_WB", {27'd0, writeReg2_WB}, {27'd0, e_wr[1]});
    check("writeData1_WB", writeData1_WB, e_wd[0]);
    check("writeData2_WB", writeData2_WB, e_wd[1]);
    check("aluRes1_WB", aluRes1_WB, e_alu[0]);
    check("aluRes2_WB", aluRes2_WB, e_alu[1]);
  endtask

  task automatic check_wb_zero();
    check("rst regWrite1", {31'd0, regWrite1_WB}, 32'd0);
    check("rst regWrite2", {31'd0, regWrite2_WB}, 32'd0);
    check("rst jal1", {31'd0, jal1_WB}, 32'd0);
    check("rst jal2", {31'd0, jal2_WB}, 32'd0);
    check("rst writeReg1", {27'd0, writeReg1_WB}, 32'd0);
    check("rst writeReg2", {27'd0, writeReg2_WB}, 32'd0);
    check("rst writeData1", writeData1_WB, 32'd0);
    check("rst writeData2", writeData2_WB, 32'd0);
    check("rst aluRes1", aluRes1_WB, 32'd0);
    check("rst aluRes2", aluRes2_WB, 32'd0);
  endtask

  initial begin
    ins_t a, b;
    logic [31:0] saved3;

    rst = 1'b1;
    a = nop(); b = nop();
    a.rw = 1'b1; a.dest = 5'd7; a.alu = 32'h1234;
    set_in(a, b);
    repeat (2) @(posedge clk);
    #1;
    check_wb_zero();
    check("rst correct_en", {31'd0, correct_en}, 32'd0);
    check("rst squash_MEM", {31'd0, squash_MEM}, 32'd0);
    a = nop(); a.br = 1'b1; a.tk = 1'b0; a.ret = 10'h3F;
    set_in(a, b);
    @(posedge clk);
    #1;
    rst = 1'b0;
    a = nop();
    set_in(a, b);
    #1;
    check("squash after rst", {31'd0, squash_MEM}, 32'd0);
    sq_m = 1'b0;

    for (int i = 0; i < 8; i++) begin
      a = nop(); b = nop();
      a.mw = 1'b1; a.alu = 32'(2 * i);     a.sd = $urandom;
      b.mw = 1'b1; b.alu = 32'(2 * i + 1); b.sd = $urandom;
      drive(a, b); clock();
    end

    a = nop(); b = nop();
    a.mw = 1'b1; a.alu = 32'd5; a.sd = 32'hDEADBEEF;
    drive(a, b); clock();
    a = nop();
    b.mr = 1'b1; b.m2r = 1'b1; b.rw = 1'b1; b.alu = 32'd5; b.dest = 5'd8;
    drive(a, b); clock();
    check("load after store data", writeData2_WB, 32'hDEADBEEF);
    check("load after store reg", {27'd0, writeReg2_WB}, 32'd8);
    check("load after store we", {31'd0, regWrite2_WB}, 32'd1);

    a = nop(); b = nop();
    a.mw = 1'b1; a.alu = 32'd7; a.sd = 32'h11;
    b.mw = 1'b1; b.alu = 32'd7; b.sd = 32'h22;
    drive(a, b); clock();
    a = nop(); b = nop();
    a.mr = 1'b1; a.m2r = 1'b1; a.rw = 1'b1; a.alu = 32'd7; a.dest = 5'd10;
    drive(a, b); clock();
    check("dual write lane2 wins", writeData1_WB, 32'h22);
    a = nop(); b = nop();
    a.mw = 1'b1; a.alu = 32'd9; a.sd = 32'h33;
    b.mr = 1'b1; b.m2r = 1'b1; b.rw = 1'b1; b.alu = 32'd9; b.dest = 5'd11;
    drive(a, b); clock();
    check("lane1 to lane2 bypass", writeData2_WB, 32'h33);

    saved3 = mem_m[3];
    a = nop(); b = nop();
    a.br = 1'b1; a.tk = 1'b0; a.ret = 10'h40;
    b.mw = 1'b1; b.alu = 32'd3; b.sd = 32'h0BAD; b.rw = 1'b1; b.dest = 5'd6;
    drive(a, b);
    check("mis1 correct_en", {31'd0, correct_en}, 32'd1);
    check("mis1 correction", {22'd0, correction}, 32'h40);
    check("mis1 flush_IFID", {31'd0, flush_IFID}, 32'd1);
    check("mis1 flush_IDEX", {31'd0, flush_IDEX}, 32'd1);
    clock();
    check("mis1 younger no write", {31'd0, regWrite2_WB}, 32'd0);
    a = nop(); b = nop();
    a.br = 1'b1; a.tk = 1'b0; a.ret = 10'h55;
    drive(a, b);
    check("squash_MEM set", {31'd0, squash_MEM}, 32'd1);
    check("squashed branch ignored", {31'd0, correct_en}, 32'd0);
    clock();
    a = nop();
    a.mr = 1'b1; a.m2r = 1'b1; a.rw = 1'b1; a.alu = 32'd3; a.dest = 5'd9;
    drive(a, b); clock();
    check("squashed store dropped", writeData1_WB, saved3);

    a = nop(); b = nop();
    a.rw = 1'b1; a.dest = 5'd4; a.alu = 32'h1234;
    b.br = 1'b1; b.tk = 1'b0; b.ret = 10'h12;
    drive(a, b);
    check("mis2 correction", {22'd0, correction}, 32'h12);
    clock();
    check("mis2 older writes", {31'd0, regWrite1_WB}, 32'd1);
    check("mis2 older reg", {27'd0, writeReg1_WB}, 32'd4);
    a = nop(); b = nop();
    drive(a, b); clock();

    a = nop();
    a.jal = 1'b1; a.ret = 10'h2A; a.dest = 5'd0; a.alu = 32'h777;
    drive(a, b);
    check("jal fwd", aluRes1_MEM_fwd, 32'h2A);
    clock();
    check("jal reg", {27'd0, writeReg1_WB}, 32'd31);
    check("jal data", writeData1_WB, 32'h2A);
    check("jal we", {31'd0, regWrite1_WB}, 32'd1);
    a = nop();
    a.rw = 1'b1; a.dest = 5'd0; a.alu = 32'd5;
    drive(a, b); clock();
    check("r0 no write", {31'd0, regWrite1_WB}, 32'd0);

    for (int n = 0; n < 300; n++) begin
      drive(rnd_ins(), rnd_ins());
      clock();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_wb_backend.md
Name: mem_wb_backend

Overview:
- Back end of the dual-issue pipeline: consumes both lanes' EX/MEM register outputs, performs data-memory access, resolves branch mispredictions and holds the MEM/WB register.
- Drives the writeback, MEM-stage forwarding and PC-correction/flush signals back into the front-end pipeline.
- Lane 1 is always the older instruction.
- Static predictor: every branch is fetched as predicted-taken, so a branch that resolves not-taken must be corrected.

Parameters:
- DATA_W, 32, datapath and memory word width
- ADDR_W, 10, data-memory word-address width (depth 2^ADDR_W)
- PC_W, 10, instruction-address width (return_addr, correction)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- aluResx_MEM  in  DATA_W  lane x ALU result / memory address (x = 1,2; same for all lane-x lines below)
- forwardBResx_MEM  in  DATA_W  lane x store data
- MemReadEnx_MEM, MemtoRegx_MEM, MemWriteEnx_MEM, RegWriteEnx_MEM, jalx_MEM  in  1 each  lane x controls
- DestRegx_MEM  in  5  lane x destination register
- return_addrx_MEM  in  PC_W  lane x PC+1
- Branchx_MEM, takenx_MEM  in  1 each  lane x is-branch / resolved-taken
- correct_en  out  1  redirect fetch this cycle
- correction  out  PC_W  redirect target
- flush_IFID, flush_IDEX  out  1 each  front-end flushes
- aluResx_MEM_fwd  out  DATA_W  lane x MEM-stage forwarding value
- regWritex_WB, jalx_WB  out  1 each  lane x writeback controls
- writeRegx_WB  out  5  lane x writeback register
- writeDatax_WB, aluResx_WB  out  DATA_W  lane x writeback data / raw ALU result
- squash_MEM  out  1  MEM contents being discarded this cycle (debug/verification)

Behaviour:
- Reset (sync, rst=1 at posedge): clear all MEM/WB registers and squash_q. All _WB outputs become 0 and squash_MEM becomes 0. Data-memory contents are not reset. Reset mid-squash cancels the squash.
- Lane validity:
  - v1 = !squash_q
  - v2 = !squash_q && !mis1
- Mispredictions:
  - misx = Branchx_MEM && !takenx_MEM && lane x valid.
  - mis1 = Branch1_MEM && !taken1_MEM && !squash_q.
- Correction (combinational, same cycle):
  - correct_en = mis1 || mis2.
  - correction = mis1 ? return_addr1_MEM : return_addr2_MEM. Lane 1 wins when both lanes mispredict.
  - flush_IFID = flush_IDEX = correct_en.
- Squash: squash_q <= correct_en at each posedge. The wrong-path instructions that move EX->MEM on that edge are discarded for exactly one cycle. A branch inside squashed contents never raises correct_en. squash_MEM = squash_q.
- Memory:
  - Dual-port sync-write, sync-read RAM addressed by aluResx_MEM[ADDR_W-1:0].
  - A write occurs only when MemWriteEnx_MEM && lane x valid.
  - Both lanes write the same address: lane 2 data is stored.
  - Read data is registered and is valid in WB one cycle later.
  - Lane 2 reads the address lane 1 writes in the same cycle: lane 2 receives lane 1's store data (bypass).
  - Lane 1 reads the address lane 2 writes in the same cycle: lane 1 receives the old data.
  - A read by either lane of an address written in the previous cycle returns the new data.
- Forwarding: aluResx_MEM_fwd = jalx_MEM ? zero-extended return_addrx_MEM : aluResx_MEM. This is combinational and unaffected by squash; the consumer qualifies it with its own hazard logic.
- MEM/WB register capture at each posedge:
  - RegWriteEnx, jalx and MemtoRegx are ANDed with lane-x valid.
  - The destination register is 31 if jalx, else DestRegx_MEM.
  - aluRes and return_addr are captured as received.
- Writeback outputs:
  - writeDatax_WB = MemtoRegx_WB ? RAM read data : (jalx_WB ? zero-extended return_addrx_WB : aluResx_WB).
  - regWritex_WB = captured RegWriteEn || captured jal, forced 0 when writeRegx_WB == 0.
- Latency: correction takes 0 cycles from MEM entry. Writeback takes 1 cycle from MEM.

Decomposition:
- Shared package holds: DATA_W/ADDR_W/PC_W defaults, RA_REG = 31, ZERO_REG = 0.
- Sub-module dmem_dp is the dual-port RAM with same-cycle lane-2-wins write priority and the lane-1-to-lane-2 read bypass.
- Misprediction, squash and MEM/WB register logic stay in mem_wb_backend.

Test Plan:
- Reset: hold rst 2 cycles with RegWriteEn1_MEM=1 -> all _WB outputs 0, correct_en 0, squash_MEM 0. Hold rst with Branch1_MEM=1, taken1_MEM=0 in the cycle before release -> squash_MEM 0 after release.
- Store/load: lane 1 stores 0xDEADBEEF at address 5. Next cycle lane 2 loads address 5 with DestReg2=8 -> one cycle later writeData2_WB=0xDEADBEEF, writeReg2_WB=8, regWrite2_WB=1.
- Same cycle, same address 7: lane 1 stores 0x11, lane 2 stores 0x22 -> a later load of address 7 returns 0x22. Lane 1 stores 0x33 to address 9 while lane 2 loads 9 -> writeData2_WB=0x33.
- Lane 1 branch, Branch1=1, taken1=0, return_addr1=0x40, with lane 2 a store to address 3 -> correct_en=1, correction=0x40, both flushes 1, address 3 unchanged, regWrite2_WB=0 next cycle. Next cycle: squash_MEM=1, and a mispredicted branch in MEM then gives correct_en=0.
- Lane 2 only mispredicts (return_addr2=0x12) while lane 1 is an add to r4 -> correction=0x12, regWrite1_WB=1 with writeReg1_WB=4 next cycle.
- jal1_MEM=1, return_addr1=0x2A, DestReg1_MEM=0 -> aluRes1_MEM_fwd=0x2A. Next cycle: writeReg1_WB=31, writeData1_WB=0x2A, regWrite1_WB=1. An add writing r0 -> regWrite_WB=0.
